// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC ownership, one-in-flight imem requests, stall/redirect
// Optional: define IF_ALIGN_CHECK_EN to add the if_misalign port and halt fetch on unaligned redirects.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
`ifdef IF_ALIGN_CHECK_EN
   output logic        if_misalign,
`endif
   output logic        if_valid
);

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic        req_q;
   logic [31:0] if_pc_q;
   logic [31:0] if_inst_q;
   logic        if_valid_q;
   logic [31:0] buf_pc_q;
   logic [31:0] buf_inst_q;
   logic        buf_valid_q;
   logic        discard_q;
   logic [31:0] pc_d;
   logic [31:0] branch_pc;

   assign pc_d = pc_q + PC_STEP;

`ifdef IF_ALIGN_CHECK_EN
   logic misalign_q;
   assign branch_pc   = branch_target;
   assign if_misalign = misalign_q;
`else
   assign branch_pc = branch_target & ~32'h3;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RST;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         req_q       <= 1'b0;
         if_pc_q     <= 32'h0;
         if_inst_q   <= 32'h0;
         if_valid_q  <= 1'b0;
         buf_pc_q    <= 32'h0;
         buf_inst_q  <= 32'h0;
         buf_valid_q <= 1'b0;
         discard_q   <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
         misalign_q  <= 1'b0;
`endif
      end
`ifdef IF_ALIGN_CHECK_EN
      else if (misalign_q) begin
         req_q <= 1'b0;
      end
`endif
      else if (branch_flag) begin
         if_valid_q  <= 1'b0;
         if_inst_q   <= 32'h0;
         buf_valid_q <= 1'b0;
         pc_q        <= branch_pc;
`ifdef IF_ALIGN_CHECK_EN
         if (branch_target[1:0] != 2'b00) begin
            misalign_q <= 1'b1;
            req_q      <= 1'b0;
            discard_q  <= 1'b0;
         end else
`endif
         // An unanswered request keeps its address on the bus; its word is dropped later.
         if (state_q == S_REQ && !imem_ack) begin
            discard_q <= 1'b1;
         end else begin
            discard_q <= 1'b0;
            addr_q    <= branch_pc;
            req_q     <= 1'b1;
            state_q   <= S_REQ;
         end
      end else begin
         case (state_q)
            S_RST: begin
               state_q <= S_REQ;
               req_q   <= 1'b1;
               addr_q  <= pc_q;
            end
            S_REQ: begin
               if (imem_ack) begin
                  if (discard_q) begin
                     discard_q <= 1'b0;
                     addr_q    <= pc_q;
                  end else if (!stall) begin
                     if_pc_q    <= pc_q;
                     if_inst_q  <= imem_rdata;
                     if_valid_q <= 1'b1;
                     pc_q       <= pc_d;
                     addr_q     <= pc_d;
                  end else begin
                     buf_pc_q    <= pc_q;
                     buf_inst_q  <= imem_rdata;
                     buf_valid_q <= 1'b1;
                     pc_q        <= pc_d;
                     addr_q      <= pc_d;
                     req_q       <= 1'b0;
                     state_q     <= S_HOLD;
                  end
               end else if (!stall) begin
                  if_valid_q <= 1'b0;
                  if_inst_q  <= 32'h0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  if_pc_q     <= buf_pc_q;
                  if_inst_q   <= buf_inst_q;
                  if_valid_q  <= buf_valid_q;
                  buf_valid_q <= 1'b0;
                  addr_q      <= pc_q;
                  req_q       <= 1'b1;
                  state_q     <= S_REQ;
               end
            end
            default: begin
               state_q <= S_RST;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign if_pc     = if_pc_q;
   assign if_inst   = if_inst_q;
   assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;

   localparam logic [31:0] SCR = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        req1, ack1, valid1, req2, ack2, valid2;
   logic [31:0] addr1, rdata1, pc1, inst1, addr2, rdata2, pc2, inst2;
   logic [31:0] wait_n;
   logic        mem_block;
   logic [31:0] cnt;
   int          checks = 0;
   int          failures = 0;
`ifdef IF_ALIGN_CHECK_EN
   logic        mis1, mis2;
`endif

   always #5 clk = ~clk;

   if_fetch dut1 (
      .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
      .branch_target(branch_target), .imem_req(req1), .imem_addr(addr1),
      .imem_ack(ack1), .imem_rdata(rdata1), .if_pc(pc1), .if_inst(inst1),
`ifdef IF_ALIGN_CHECK_EN
      .if_misalign(mis1),
`endif
      .if_valid(valid1)
   );

   if_fetch #(.RESET_PC(32'hFFFFFFF8)) dut2 (
      .clk(clk), .rst(rst), .stall(1'b0), .branch_flag(1'b0),
      .branch_target(32'h0), .imem_req(req2), .imem_addr(addr2),
      .imem_ack(ack2), .imem_rdata(rdata2), .if_pc(pc2), .if_inst(inst2),
`ifdef IF_ALIGN_CHECK_EN
      .if_misalign(mis2),
`endif
      .if_valid(valid2)
   );

   // Memory for dut1 answers after wait_n cycles of an asserted request.
   assign ack1   = req1 && !mem_block && (cnt >= wait_n);
   assign rdata1 = addr1 ^ SCR;
   assign ack2   = req2;
   assign rdata2 = addr2 ^ SCR;

   always @(posedge clk) begin
      if (rst || !req1 || ack1) cnt <= 32'h0;
      else                      cnt <= cnt + 32'h1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
      wait_n = 32'd0; mem_block = 1'b0;
      @(negedge clk);

      // Reset state and zero-wait streaming, plus the wrap-around instance.
      do_reset();
      check("rst_req", {31'h0, req1}, 32'h0);
      check("rst_addr", addr1, 32'h0);
      check("rst_pc", pc1, 32'h0);
      check("rst_inst", inst1, 32'h0);
      check("rst_valid", {31'h0, valid1}, 32'h0);
      check("rst_addr2", addr2, 32'hFFFFFFF8);
      step();
      check("first_req", {31'h0, req1}, 32'h1);
      check("first_addr", addr1, 32'h0);
      check("first_valid", {31'h0, valid1}, 32'h0);
      step();
      check("pc0", pc1, 32'h0);
      check("inst0", inst1, 32'h0 ^ SCR);
      check("valid0", {31'h0, valid1}, 32'h1);
      check("wrap_pc0", pc2, 32'hFFFFFFF8);
      step();
      check("pc4", pc1, 32'h4);
      check("wrap_pc1", pc2, 32'hFFFFFFFC);
      step();
      check("pc8", pc1, 32'h8);
      check("addr12", addr1, 32'hC);
      check("wrap_pc2", pc2, 32'h0);
      check("wrap_inst2", inst2, 32'h0 ^ SCR);

      // Stall while the ack for 12 arrives.
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall_pc", pc1, 32'h8);
         check("stall_req", {31'h0, req1}, 32'h0);
         check("stall_valid", {31'h0, valid1}, 32'h1);
      end
      stall = 1'b0;
      step();
      check("rel_pc", pc1, 32'hC);
      check("rel_inst", inst1, 32'hC ^ SCR);
      check("rel_req", {31'h0, req1}, 32'h1);
      check("rel_addr", addr1, 32'h10);
      step();
      check("rel_pc16", pc1, 32'h10);

      // Three wait states per request.
      wait_n = 32'd3;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         check("wait_addr0", addr1, 32'h0);
         check("wait_bubble0", {31'h0, valid1}, 32'h0);
      end
      step();
      check("wait_pc0", pc1, 32'h0);
      check("wait_valid0", {31'h0, valid1}, 32'h1);
      step();
      check("wait_bubble", {31'h0, valid1}, 32'h0);
      check("wait_bubble_inst", inst1, 32'h0);
      check("wait_addr4", addr1, 32'h4);
      step();
      step();
      check("wait_addr4_hold", addr1, 32'h4);
      step();
      check("wait_pc4", pc1, 32'h4);
      check("wait_valid4", {31'h0, valid1}, 32'h1);

      // Redirect while the request to 0x20 is still unanswered.
      wait_n = 32'd0;
      do_reset();
      n = 0;
      while (addr1 != 32'h20 && n < 20) begin
         step();
         n++;
      end
      check("reach_0x20", addr1, 32'h20);
      mem_block = 1'b1;
      branch_flag = 1'b1;
      branch_target = 32'h100;
      step();
      branch_flag = 1'b0;
      check("br_valid", {31'h0, valid1}, 32'h0);
      check("br_inst", inst1, 32'h0);
      check("br_addr_held", addr1, 32'h20);
      check("br_req", {31'h0, req1}, 32'h1);
      step();
      check("br_addr_held2", addr1, 32'h20);
      mem_block = 1'b0;
      step();
      check("br_drop_valid", {31'h0, valid1}, 32'h0);
      check("br_new_addr", addr1, 32'h100);
      step();
      check("br_pc", pc1, 32'h100);
      check("br_inst_tgt", inst1, 32'h100 ^ SCR);
      check("br_valid_tgt", {31'h0, valid1}, 32'h1);
      step();
      check("br_pc_next", pc1, 32'h104);

      // Unaligned redirect target.
      branch_flag = 1'b1;
      branch_target = 32'h102;
      step();
      branch_flag = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      check("mis_flag", {31'h0, mis1}, 32'h1);
      check("mis_req", {31'h0, req1}, 32'h0);
      check("mis_valid", {31'h0, valid1}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("mis_sticky", {31'h0, mis1}, 32'h1);
         check("mis_req_low", {31'h0, req1}, 32'h0);
      end
      do_reset();
      check("mis_clear", {31'h0, mis1}, 32'h0);
`else
      check("align_addr", addr1, 32'h100);
      check("align_valid", {31'h0, valid1}, 32'h0);
      step();
      check("align_pc", pc1, 32'h100);
      check("align_valid1", {31'h0, valid1}, 32'h1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
